// File: rtl/load_store_unit.sv
// load_store_unit: RISC-V B/H/W loads and stores onto a word memory; `LSU_MISALIGN_TRAP_EN traps misaligned requests.
// Latency accept->RespValid: 2 cycles aligned, 3 cycles word-spanning, 1 cycle illegal.
// Backpressure: ReqReady only in IDLE, ReqValid ignored while busy; response is a one-cycle pulse.
module load_store_unit #(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [2:0]  ReqFunct3,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RespValid,
  output logic        RespErr,
  output logic [31:0] RespRData,
  output logic [31:0] MemAddress,
  output logic        MemWE,
  output logic [31:0] MemWriteData,
  input  logic [31:0] MemReadData
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
  state_t state_q, state_d;

  logic                 write_q, err_q;
  logic [2:0]           f3_q;
  logic [ADDR_BITS+1:0] addr_q;
  logic [31:0]          wdata_q, ld_q, rdata_q;

  logic legal_op, misalign, req_illegal, load_done;
  logic unused_addr_hi;

  always_comb begin
    legal_op = 1'b0;
    if (ReqWrite) legal_op = ReqFunct3 inside {3'b000, 3'b001, 3'b010};
    else          legal_op = ReqFunct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((ReqFunct3[1:0] == 2'b01) && ReqAddr[0]) ||
                    ((ReqFunct3[1:0] == 2'b10) && (ReqAddr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_illegal    = !legal_op || misalign;
  assign unused_addr_hi = ^ReqAddr[31:ADDR_BITS+2];

  // Lane enables over an 8-byte window: [3:0] hit word0, [7:4] spill into word1.
  logic [1:0]           off;
  logic [3:0]           size_mask;
  logic [7:0]           be;
  logic [63:0]          wdata_sh;
  logic                 spans;
  logic [ADDR_BITS-1:0] word0, word1;

  assign off = addr_q[1:0];

  always_comb begin
    case (f3_q[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  assign be       = {4'b0000, size_mask} << off;
  assign wdata_sh = {32'd0, wdata_q} << {off, 3'b000};
  assign spans    = |be[7:4];
  assign word0    = addr_q[ADDR_BITS+1:2];
  assign word1    = (word0 + 1'b1) & ADDR_BITS'(MEM_WORDS - 1);

  function automatic logic [31:0] lane_mask(input logic [3:0] b);
    return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction

  // Load bytes land at result byte 0 upward; ACC1 continues above what ACC0 captured.
  logic [31:0] ld_lo, ld_full, ld_ext;
  assign ld_lo   = MemReadData >> {off, 3'b000};
  assign ld_full = (state_q == ACC1) ? (ld_q | (MemReadData << (6'd32 - {1'b0, off, 3'b000})))
                                     : ld_lo;

  always_comb begin
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_full[7]}}, ld_full[7:0]};
      3'b001:  ld_ext = {{16{ld_full[15]}}, ld_full[15:0]};
      3'b100:  ld_ext = {24'd0, ld_full[7:0]};
      3'b101:  ld_ext = {16'd0, ld_full[15:0]};
      default: ld_ext = ld_full;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    MemWE        = 1'b0;
    MemAddress   = '0;
    MemWriteData = '0;
    load_done    = 1'b0;
    case (state_q)
      IDLE: if (ReqValid) state_d = req_illegal ? RESP : ACC0;
      ACC0: begin
        MemAddress   = {{(32-ADDR_BITS){1'b0}}, word0};
        MemWE        = write_q;
        MemWriteData = (MemReadData & ~lane_mask(be[3:0])) | (wdata_sh[31:0] & lane_mask(be[3:0]));
        load_done    = !write_q && !spans;
        state_d      = spans ? ACC1 : RESP;
      end
      ACC1: begin
        MemAddress   = {{(32-ADDR_BITS){1'b0}}, word1};
        MemWE        = write_q;
        MemWriteData = (MemReadData & ~lane_mask(be[7:4])) | (wdata_sh[63:32] & lane_mask(be[7:4]));
        load_done    = !write_q;
        state_d      = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && ReqValid) begin
        write_q <= ReqWrite;
        f3_q    <= ReqFunct3;
        addr_q  <= ReqAddr[ADDR_BITS+1:0];
        wdata_q <= ReqWData;
        err_q   <= req_illegal;
      end
      if (state_q == ACC0) ld_q <= ld_lo;
      if (load_done) rdata_q <= ld_ext;
    end
  end

  assign ReqReady  = (state_q == IDLE);
  assign RespValid = (state_q == RESP);
  assign RespErr   = RespValid && err_q;
  assign RespRData = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural 1024x32 memory; honours LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ReqValid, ReqReady, ReqWrite;
  logic [2:0]  ReqFunct3;
  logic [31:0] ReqAddr, ReqWData;
  logic        RespValid, RespErr;
  logic [31:0] RespRData, MemAddress, MemWriteData, MemReadData;
  logic        MemWE;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(1024), .ADDR_BITS(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqFunct3(ReqFunct3), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .RespValid(RespValid), .RespErr(RespErr), .RespRData(RespRData),
    .MemAddress(MemAddress), .MemWE(MemWE), .MemWriteData(MemWriteData),
    .MemReadData(MemReadData)
  );

  // Memory model: combinational read, posedge write, plus a backdoor write port for preloading.
  logic [31:0] mem [1024];
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [31:0] bd_dat;

  assign MemReadData = mem[MemAddress[9:0]];
  always @(posedge clk) begin
    if (MemWE) mem[MemAddress[9:0]] <= MemWriteData;
    else if (bd_we) mem[bd_addr] <= bd_dat;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  string       cq_name[$];
  logic [31:0] cq_act[$], cq_exp[$];
  logic [31:0] alog[$];
  int          we_cnt = 0;
  int          tests = 0, fails = 0;

  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, a, e);
    end
  endtask

  // Monitor: pops the scoreboard on every response and drains queued direct checks.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && RespValid) begin
      if (sb.size() == 0) begin
        cmp("resp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        cmp("resp_err", {31'd0, RespErr}, {31'd0, e.err});
        cmp("resp_rdata", RespRData, e.rd);
        cmp("resp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
    if (rst_n && !ReqReady && !RespValid) alog.push_back(MemAddress);
    if (MemWE) we_cnt++;
    while (cq_name.size() > 0) cmp(cq_name.pop_front(), cq_act.pop_front(), cq_exp.pop_front());
  end

  task automatic dchk(input string nm, input logic [31:0] a, input logic [31:0] e);
    cq_name.push_back(nm);
    cq_act.push_back(a);
    cq_exp.push_back(e);
  endtask

  task automatic poke(input int addr, input logic [31:0] dat);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = 10'(addr); bd_dat = dat;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic eerr, input logic [31:0] erd,
                       input int elat, input bit resp);
    int n = 0;
    @(negedge clk);
    ReqValid = 1'b1; ReqWrite = wr; ReqFunct3 = f3; ReqAddr = a; ReqWData = wd;
    while (!ReqReady && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ReqReady) dchk("accept_timeout", 32'd0, 32'd1);
    if (resp) sb.push_back('{eerr, erd, elat, cyc + 1});
    @(posedge clk);
    #1 ReqValid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || !ReqReady) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) dchk("done_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  function automatic logic [31:0] alog_at(input int base, input int idx);
    return (alog.size() > base + idx) ? alog[base + idx] : 32'hFFFF_FFFF;
  endfunction

  initial begin
    int          w0, a0;
    logic [31:0] lastrd;

    rst_n = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqFunct3 = '0;
    ReqAddr = '0; ReqWData = '0; bd_we = 1'b0; bd_addr = '0; bd_dat = '0;
    repeat (3) @(negedge clk);
    dchk("rst_ready", {31'd0, ReqReady}, 32'd1);
    dchk("rst_respvalid", {31'd0, RespValid}, 32'd0);
    dchk("rst_resperr", {31'd0, RespErr}, 32'd0);
    dchk("rst_rdata", RespRData, 32'd0);
    dchk("rst_memwe", {31'd0, MemWE}, 32'd0);
    dchk("rst_memaddr", MemAddress, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Aligned SW
    w0 = we_cnt; a0 = alog.size();
    issue(1'b1, 3'b010, 32'h80, 32'hDEADBEEF, 1'b0, 32'd0, 2, 1'b1);
    wait_done();
    dchk("sw_mem32", mem[32], 32'hDEADBEEF);
    dchk("sw_we_cycles", 32'(we_cnt - w0), 32'd1);
    dchk("sw_acc_count", 32'(alog.size() - a0), 32'd1);
    dchk("sw_acc_addr", alog_at(a0, 0), 32'd32);

    // SB merge then sub-word loads
    poke(32, 32'h11223344);
    issue(1'b1, 3'b000, 32'h81, 32'h123456AA, 1'b0, 32'd0, 2, 1'b1);
    wait_done();
    dchk("sb_mem32", mem[32], 32'h1122AA44);
    issue(1'b0, 3'b000, 32'h81, 32'd0, 1'b0, 32'hFFFFFFAA, 2, 1'b1);
    issue(1'b0, 3'b100, 32'h81, 32'd0, 1'b0, 32'h000000AA, 2, 1'b1);
    issue(1'b0, 3'b001, 32'h82, 32'd0, 1'b0, 32'h00001122, 2, 1'b1);
    wait_done();
    lastrd = 32'h00001122;

    // Misaligned LW across words 32/33
    poke(32, 32'h11223344);
    poke(33, 32'h55667788);
    a0 = alog.size();
    issue(1'b0, 3'b010, 32'h83, 32'd0, TRAP, TRAP ? lastrd : 32'h66778811, TRAP ? 1 : 3, 1'b1);
    wait_done();
    lastrd = TRAP ? lastrd : 32'h66778811;
    dchk("lw83_acc_count", 32'(alog.size() - a0), TRAP ? 32'd0 : 32'd2);
    dchk("lw83_acc0", alog_at(a0, 0), TRAP ? 32'hFFFF_FFFF : 32'd32);
    dchk("lw83_acc1", alog_at(a0, 1), TRAP ? 32'hFFFF_FFFF : 32'd33);

    // SH wrapping from word 1023 into word 0, then LH back
    poke(1023, 32'hA1A2A3A4);
    poke(0, 32'hB1B2B3B4);
    w0 = we_cnt;
    issue(1'b1, 3'b001, 32'hFFF, 32'h1234BEEF, TRAP, lastrd, TRAP ? 1 : 3, 1'b1);
    wait_done();
    dchk("sh_wrap_mem1023", mem[1023], TRAP ? 32'hA1A2A3A4 : 32'hEFA2A3A4);
    dchk("sh_wrap_mem0", mem[0], TRAP ? 32'hB1B2B3B4 : 32'hB1B2B3BE);
    dchk("sh_wrap_we_cycles", 32'(we_cnt - w0), TRAP ? 32'd0 : 32'd2);
    issue(1'b0, 3'b001, 32'hFFF, 32'd0, TRAP, TRAP ? lastrd : 32'hFFFFBEEF, TRAP ? 1 : 3, 1'b1);
    wait_done();
    lastrd = TRAP ? lastrd : 32'hFFFFBEEF;

    // Illegal funct3 for load and store
    w0 = we_cnt;
    issue(1'b0, 3'b011, 32'h80, 32'd0, 1'b1, lastrd, 1, 1'b1);
    issue(1'b1, 3'b100, 32'h80, 32'hFFFFFFFF, 1'b1, lastrd, 1, 1'b1);
    issue(1'b1, 3'b101, 32'h80, 32'hFFFFFFFF, 1'b1, lastrd, 1, 1'b1);
    wait_done();
    dchk("illegal_we_cycles", 32'(we_cnt - w0), 32'd0);
    dchk("illegal_mem32", mem[32], 32'h11223344);

    // ReqValid held high while busy: each accept must wait for ReqReady
    issue(1'b0, 3'b010, 32'h80, 32'd0, 1'b0, 32'h11223344, 2, 1'b1);
    issue(1'b0, 3'b010, 32'h84, 32'd0, 1'b0, 32'h55667788, 2, 1'b1);
    issue(1'b0, 3'b101, 32'h86, 32'd0, 1'b0, 32'h00005566, 2, 1'b1);
    wait_done();

    // Reset during ACC1 of a spanning SW
    poke(64, 32'h12345678);
    poke(65, 32'h9ABCDEF0);
    issue(1'b1, 3'b010, 32'h102, 32'hCAFEF00D, 1'b1, 32'h00005566, 1, TRAP);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    dchk("midrst_memwe", {31'd0, MemWE}, 32'd0);
    dchk("midrst_memaddr", MemAddress, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    dchk("midrst_ready", {31'd0, ReqReady}, 32'd1);
    dchk("midrst_rdata", RespRData, 32'd0);
    dchk("midrst_mem64", mem[64], TRAP ? 32'h12345678 : 32'hF00D5678);
    dchk("midrst_mem65", mem[65], 32'h9ABCDEF0);
    dchk("midrst_pending", 32'(sb.size()), 32'd0);
    issue(1'b0, 3'b010, 32'h100, 32'd0, 1'b0, TRAP ? 32'h12345678 : 32'hF00D5678, 2, 1'b1);
    wait_done();

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
